// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, lamp codes and default phase durations
package traffic_pkg;
  typedef enum logic [2:0] {
    NS_GRN   = 3'd0,
    NS_YEL   = 3'd1,
    RED_A    = 3'd2,
    PED_WALK = 3'd3,
    EW_GRN   = 3'd4,
    EW_YEL   = 3'd5,
    RED_B    = 3'd6
  } state_t;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam int D_NS_MIN = 8;
  localparam int D_EW_GRN = 6;
  localparam int D_YEL    = 3;
  localparam int D_RED    = 1;
  localparam int D_WALK   = 5;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: 4-bit tick-enabled down counter with load and zero flag
module phase_timer #(
  parameter logic [3:0] RST_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt;
  // load wins; otherwise count down once per tick, parking at zero
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (tick && cnt != 4'd0) cnt <= cnt - 4'd1;
  assign zero = cnt == 4'd0;
endmodule

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-road intersection controller with pedestrian phase
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int T_NS_MIN = D_NS_MIN,
  parameter int T_EW_GRN = D_EW_GRN,
  parameter int T_YEL    = D_YEL,
  parameter int T_RED    = D_RED,
  parameter int T_WALK   = D_WALK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ew_sensor,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] state_o
);
  localparam logic [3:0] L_NS  = 4'(T_NS_MIN - 1);
  localparam logic [3:0] L_EW  = 4'(T_EW_GRN - 1);
  localparam logic [3:0] L_YEL = 4'(T_YEL - 1);
  localparam logic [3:0] L_RED = 4'(T_RED - 1);
  localparam logic [3:0] L_WLK = 4'(T_WALK - 1);
  state_t state, state_next;
  logic zero, adv, entry, ew_pend, ped_pend;
  logic [3:0] load_val;
  assign adv   = tick & zero;
  assign entry = state_next != state;
  phase_timer #(.RST_VAL(L_NS)) u_timer (
    .clk(clk), .reset(reset), .tick(tick), .load(entry), .load_val(load_val), .zero(zero)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= NS_GRN;
    else state <= state_next;
  // next state: leave a phase only on a tick with the timer expired; stray codes go to all-red
  always_comb begin
    state_next = state;
    case (state)
      NS_GRN:   state_next = (adv && (ew_pend || ped_pend)) ? NS_YEL : NS_GRN;
      NS_YEL:   state_next = adv ? RED_A : NS_YEL;
      RED_A:    state_next = adv ? (ped_pend ? PED_WALK : EW_GRN) : RED_A;
      PED_WALK: state_next = adv ? (ew_pend ? EW_GRN : NS_GRN) : PED_WALK;
      EW_GRN:   state_next = adv ? EW_YEL : EW_GRN;
      EW_YEL:   state_next = adv ? RED_B : EW_YEL;
      RED_B:    state_next = adv ? NS_GRN : RED_B;
      default:  state_next = RED_B;
    endcase
  end
  // duration-1 of the phase being entered
  always_comb
    load_val = state_next == NS_GRN   ? L_NS  :
               state_next == EW_GRN   ? L_EW  :
               state_next == PED_WALK ? L_WLK :
               (state_next == NS_YEL || state_next == EW_YEL) ? L_YEL : L_RED;
  // request latches: served phase entry clears, beating a same-cycle set
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ew_pend  <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      ew_pend  <= (entry && state_next == EW_GRN)   ? 1'b0 : ew_pend | ew_sensor;
      ped_pend <= (entry && state_next == PED_WALK) ? 1'b0 : ped_pend | ped_req;
    end
  // Moore lamp decode from registered state
  always_comb begin
    ns_light = state == NS_GRN ? GRN : state == NS_YEL ? YEL : RED;
    ew_light = state == EW_GRN ? GRN : state == EW_YEL ? YEL : RED;
    walk     = state == PED_WALK;
    ped_wait = ped_pend;
    state_o  = state;
  end
endmodule

// File: tb/tb_traffic_ctrl.sv
// tb_traffic_ctrl: randomized and directed checks against a tick-level reference model
module tb_traffic_ctrl;
  import traffic_pkg::*;
  localparam int P_NS = 8, P_EW = 6, P_Y = 3, P_R = 1, P_W = 5;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, ew_sensor = 1'b0, ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, state_o;
  logic walk, ped_wait;
  int checks = 0, errors = 0;
  state_t m_st;
  int m_rem;
  bit m_ew, m_ped;

  traffic_ctrl #(.T_NS_MIN(P_NS), .T_EW_GRN(P_EW), .T_YEL(P_Y), .T_RED(P_R), .T_WALK(P_W)) dut (
    .clk(clk), .reset(reset), .tick(tick), .ew_sensor(ew_sensor), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .ped_wait(ped_wait), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(input state_t s);
    case (s)
      NS_GRN:   return P_NS;
      EW_GRN:   return P_EW;
      PED_WALK: return P_W;
      NS_YEL, EW_YEL: return P_Y;
      default:  return P_R;
    endcase
  endfunction

  task automatic model_reset();
    m_st = NS_GRN; m_rem = P_NS; m_ew = 0; m_ped = 0;
  endtask

  // m_rem counts ticks still owed to the current phase, including the one that ends it
  task automatic model_update();
    state_t nx = m_st;
    bit to_ew = 0, to_ped = 0;
    if (tick) begin
      if (m_rem > 1) m_rem--;
      else begin
        case (m_st)
          NS_GRN:   if (m_ew || m_ped) nx = NS_YEL;
          NS_YEL:   nx = RED_A;
          RED_A:    nx = m_ped ? PED_WALK : EW_GRN;
          PED_WALK: nx = m_ew ? EW_GRN : NS_GRN;
          EW_GRN:   nx = EW_YEL;
          EW_YEL:   nx = RED_B;
          default:  nx = NS_GRN;
        endcase
        if (nx != m_st) begin
          m_rem = dur(nx);
          to_ew = nx == EW_GRN;
          to_ped = nx == PED_WALK;
        end
      end
    end
    m_ew  = to_ew ? 1'b0 : (m_ew | ew_sensor);
    m_ped = to_ped ? 1'b0 : (m_ped | ped_req);
    m_st  = nx;
  endtask

  task automatic compare_all();
    logic [2:0] ens, eew;
    ens = m_st == NS_GRN ? 3'b001 : m_st == NS_YEL ? 3'b010 : 3'b100;
    eew = m_st == EW_GRN ? 3'b001 : m_st == EW_YEL ? 3'b010 : 3'b100;
    chk("ns_light", 8'(ns_light), 8'(ens));
    chk("ew_light", 8'(ew_light), 8'(eew));
    chk("walk", 8'(walk), 8'(m_st == PED_WALK));
    chk("ped_wait", 8'(ped_wait), 8'(m_ped));
    chk("state_o", 8'(state_o), 8'(m_st));
    chk("safety", 8'((ns_light[0] && ew_light[0]) || (walk && (ns_light[1:0] != 2'b00 || ew_light[1:0] != 2'b00))), 8'd0);
  endtask

  task automatic step(input logic t, input logic s, input logic p);
    tick = t; ew_sensor = s; ped_req = p;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  // four clocks per tick, requests presented on the first clock only
  task automatic tick_step(input logic s, input logic p);
    step(1'b0, s, p);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick_step(1'b0, 1'b0);
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ns", 8'(ns_light), 8'h01);
    chk("rst_ew", 8'(ew_light), 8'h04);
    chk("rst_walk", 8'(walk), 8'h00);
    chk("rst_wait", 8'(ped_wait), 8'h00);
    chk("rst_state", 8'(state_o), 8'(NS_GRN));
    reset = 1'b0;
    idle_ticks(100);
    idle_ticks(2);
    tick_step(1'b1, 1'b0);
    idle_ticks(40);
    idle_ticks(10);
    tick_step(1'b0, 1'b1);
    idle_ticks(30);
    tick_step(1'b1, 1'b1);
    idle_ticks(40);
    for (int i = 0; i < 100; i++) tick_step(1'b1, 1'b0);
    idle_ticks(30);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0);
    idle_ticks(30);
    guard = 0;
    tick_step(1'b1, 1'b0);
    while (!(m_st == EW_GRN && m_rem == 3) && guard < 200) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      guard++;
    end
    chk("reach_ew_grn", 8'(m_st == EW_GRN), 8'd1);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_ns", 8'(ns_light), 8'h01);
    chk("async_ew", 8'(ew_light), 8'h04);
    chk("async_walk", 8'(walk), 8'h00);
    chk("async_wait", 8'(ped_wait), 8'h00);
    chk("async_state", 8'(state_o), 8'(NS_GRN));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick_step(1'b1, 1'b0);
    idle_ticks(30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
